// File: rtl/inst_mem_loader.sv
// Writable instruction memory fed by a big-endian byte stream; holds the CPU in
// reset while loading and serves combinational fetches from address[AW+1:2].
module inst_mem_loader #(
  parameter int WORDS = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  load_len,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [31:0] address,
  output logic [31:0] instruction,
  output logic        cpu_hold,
  output logic        done,
  output logic [5:0]  words_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t         state, state_nx;
  logic [5:0]     len;
  logic [5:0]     len_clamped;
  logic [1:0]     byte_cnt;
  logic [AW-1:0]  word_ptr;
  logic [23:0]    asm_q;
  logic [31:0]    mem [WORDS];
  logic           accept;
  logic           word_wr;
  logic           start_ok;
  logic           unused_addr;

  assign len_clamped = (load_len > 6'(WORDS)) ? 6'(WORDS) : load_len;

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    accept     = 1'b0;
    word_wr    = 1'b0;
    start_ok   = 1'b0;
    case (state)
      IDLE: begin
        start_ok = start;
        if (start) state_nx = (load_len == 6'd0) ? DONE : LOAD;
      end
      LOAD: begin
        byte_ready = 1'b1;
        accept     = byte_valid;
        word_wr    = byte_valid && (byte_cnt == 2'd3);
        // Finish on the same edge that writes the final word.
        if (word_wr && (words_loaded + 6'd1 == len)) state_nx = DONE;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        start_ok = start;
        if (start) state_nx = (load_len == 6'd0) ? DONE : LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      byte_cnt     <= '0;
      word_ptr     <= '0;
      words_loaded <= '0;
      asm_q        <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        len          <= len_clamped;
        byte_cnt     <= '0;
        word_ptr     <= '0;
        words_loaded <= '0;
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    asm_q[23:16] <= byte_in;
          2'd1:    asm_q[15:8]  <= byte_in;
          2'd2:    asm_q[7:0]   <= byte_in;
          default: ;
        endcase
      end
      if (word_wr) begin
        word_ptr     <= word_ptr + 1'b1;
        words_loaded <= words_loaded + 6'd1;
      end
    end
  end

  // Memory contents survive reset; reset only blocks a write on its own edge.
  always_ff @(posedge clk) begin
    if (word_wr && !reset) mem[word_ptr] <= {asm_q, byte_in};
  end

  assign instruction = mem[address[AW+1:2]];
  assign unused_addr = ^{address[31:AW+2], address[1:0]};

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected words are queued as bytes are
// driven and compared against the fetch port once the load completes.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid, byte_ready, cpu_hold, done;
  logic [5:0]  load_len, words_loaded;
  logic [7:0]  byte_in;
  logic [31:0] address, instruction;

  always #5 clk = ~clk;

  inst_mem_loader #(.WORDS(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .address(address), .instruction(instruction), .cpu_hold(cpu_hold),
    .done(done), .words_loaded(words_loaded)
  );

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} exp_t;

  exp_t        sb[$];
  logic [31:0] src[$];
  logic [31:0] model [32];
  int          errors = 0;
  int          checks = 0;
  int          exp_wl = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input int idx, input logic [31:0] addr);
    sb.push_back({addr, model[idx]});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      address = e.addr;
      #1;
      check($sformatf("mem@%08h", e.addr), instruction, e.data);
    end
  endtask

  task automatic do_start(input logic [5:0] len);
    start = 1'b1;
    load_len = len;
    tick();
    start = 1'b0;
    load_len = 6'($urandom);
    exp_wl = 0;
    check("start_hold", {31'd0, cpu_hold}, (len == 0) ? 32'd0 : 32'd1);
    check("start_done", {31'd0, done}, (len == 0) ? 32'd1 : 32'd0);
    check("start_ready", {31'd0, byte_ready}, (len == 0) ? 32'd0 : 32'd1);
    check("start_wl", {26'd0, words_loaded}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int n;
    gap = (max_gap > 0) ? $urandom_range(1, max_gap) : 0;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      byte_in = 8'($urandom);
      tick();
      check("gap_wl", {26'd0, words_loaded}, 32'(exp_wl));
    end
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!byte_ready) check("ready_timeout", 32'd0, 32'd1);
    else tick();
    byte_valid = 1'b0;
  endtask

  task automatic load(input int nw, input int max_gap, input int pulse_at);
    logic [31:0] w;
    for (int wi = 0; wi < nw; wi++) begin
      w = src[wi];
      for (int k = 0; k < 4; k++) begin
        if (wi * 4 + k == pulse_at) begin
          start = 1'b1;
          load_len = 6'd1;
        end
        send_byte(w[31 - 8 * k -: 8], max_gap);
        start = 1'b0;
      end
      exp_wl++;
      model[wi] = w;
      push_model(wi, 32'(wi * 4) | 32'($urandom_range(0, 3)));
    end
    check("load_wl", {26'd0, words_loaded}, 32'(exp_wl));
    check("load_done", {31'd0, done}, 32'd1);
    check("load_hold", {31'd0, cpu_hold}, 32'd0);
    check("load_ready", {31'd0, byte_ready}, 32'd0);
  endtask

  task automatic rand_src(input int n);
    src = {};
    for (int i = 0; i < n; i++) src.push_back($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; load_len = '0; byte_in = '0;
    byte_valid = 1'b0; address = '0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_wl", {26'd0, words_loaded}, 32'd0);

    // Basic three-word load, continuous valid
    src = '{32'h3C010000, 32'h34240050, 32'h20050004};
    do_start(6'd3);
    load(3, 0, -1);
    sb.push_back({32'h00000000, 32'h3C010000});
    sb.push_back({32'h00000004, 32'h34240050});
    sb.push_back({32'h0000000A, 32'h20050004});
    drain();

    // Gapped loads: scramble then restore the same program
    rand_src(3);
    do_start(6'd3);
    load(3, 3, -1);
    drain();
    src = '{32'h3C010000, 32'h34240050, 32'h20050004};
    do_start(6'd3);
    load(3, 3, -1);
    drain();

    // Reset mid-load after five bytes
    rand_src(2);
    do_start(6'd2);
    for (int k = 0; k < 5; k++) begin
      logic [31:0] w;
      w = (k < 4) ? src[0] : src[1];
      send_byte(w[31 - 8 * (k % 4) -: 8], 0);
    end
    model[0] = src[0];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_hold", {31'd0, cpu_hold}, 32'd1);
    check("midrst_ready", {31'd0, byte_ready}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_wl", {26'd0, words_loaded}, 32'd0);
    push_model(0, 32'h0);
    push_model(1, 32'h4);
    drain();
    src = '{32'hAC820000};
    do_start(6'd1);
    load(1, 0, -1);
    sb.push_back({32'h00000000, 32'hAC820000});
    push_model(1, 32'h4);
    drain();

    // Zero length, then clamped oversize load
    do_start(6'd0);
    push_model(0, 32'h0);
    push_model(1, 32'h4);
    push_model(2, 32'h8);
    drain();
    rand_src(32);
    do_start(6'd40);
    load(32, 0, -1);
    byte_valid = 1'b1;
    byte_in = 8'hFF;
    tick(); tick();
    byte_valid = 1'b0;
    check("clamp_wl", {26'd0, words_loaded}, 32'd32);
    push_model(31, 32'h0000007C);
    push_model(0, 32'hFFFFFF81);
    push_model(0, 32'h00000000);
    drain();

    // Start pulse ignored mid-load, then reload from DONE
    rand_src(3);
    do_start(6'd3);
    load(3, 0, 6);
    drain();
    rand_src(1);
    do_start(6'd1);
    load(1, 0, -1);
    push_model(1, 32'h4);
    push_model(2, 32'h8);
    drain();

    // Reset and start on the same edge: reset wins
    reset = 1'b1;
    start = 1'b1;
    load_len = 6'd5;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("rststart_ready", {31'd0, byte_ready}, 32'd0);
    check("rststart_hold", {31'd0, cpu_hold}, 32'd1);
    check("rststart_done", {31'd0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writable 32-word instruction memory with a byte-stream loader port.
- Accepts bytes over a valid/ready handshake, assembles them big-endian into 32-bit instructions, and writes them sequentially from word 0.
- Holds the single-cycle CPU in reset (cpu_hold) while loading.
- Serves the CPU fetch path combinationally, indexed by byte address bits [6:2].

Parameters:
- WORDS, 32, number of instruction words; power of two.
- AW, 5, word-address width (log2 WORDS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse to begin a load.
- load_len  in  6  number of words to load; sampled when start is accepted.
- byte_in  in  8  loader data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- address  in  32  CPU fetch byte address.
- instruction  out  32  mem[address[AW+1:2]]; combinational.
- cpu_hold  out  1  CPU must be held in reset while high.
- done  out  1  load complete, memory stable.
- words_loaded  out  6  count of words written in the current or last load.

Behaviour:
- Reset values (registered, synchronous):
  - state=IDLE, cpu_hold=1, done=0, byte_ready=0, words_loaded=0.
  - Internal counters: byte_cnt=0, word_ptr=0.
  - Memory contents are not cleared by reset.
- States:
  - IDLE: byte_ready=0, cpu_hold=1, done=0.
  - LOAD: byte_ready=1, cpu_hold=1, done=0.
  - DONE: byte_ready=0, cpu_hold=0, done=1.
- Transitions:
  - IDLE or DONE, start=1 → LOAD. On that edge: latch len = min(load_len, 32), clear byte_cnt, word_ptr, words_loaded. byte_ready is high the following cycle.
  - IDLE or DONE, start=1 with load_len=0 → DONE directly. words_loaded=0; memory untouched.
  - LOAD, start=1 → ignored.
  - LOAD, last byte of word len-1 accepted → DONE on the same edge.
- Byte handshake:
  - A byte is accepted on a rising edge where byte_valid && byte_ready.
  - A byte_valid gap stalls with no state change.
  - byte_in is ignored whenever byte_ready=0.
- Word assembly (big-endian):
  - Byte 0 → bits [31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
  - byte_cnt counts 0..3 and wraps to 0 after byte 3.
  - On the edge accepting byte 3, the word is written to mem[word_ptr], then word_ptr++ and words_loaded++. No extra cycle.
  - A written word is visible on instruction the cycle after the write edge. There is no same-cycle bypass.
- Read path:
  - instruction = mem[address[6:2]], purely combinational, valid in every state, including mid-load.
  - address bits [1:0] and [31:7] are ignored; out-of-range addresses alias.
- Boundaries:
  - load_len > 32 is clamped to 32.
  - word_ptr never exceeds 31 within a load.
  - Reset asserted mid-load → IDLE next edge. Words already written are kept. The partial word in the assembly register is discarded. cpu_hold stays 1.
  - start on the same edge as reset: reset wins.
  - Reload from DONE: cpu_hold rises the cycle after start. Words beyond the new len keep their old contents.

Test Plan:
1. Reset, then idle 3 cycles → cpu_hold=1, done=0, byte_ready=0, words_loaded=0.
2. start, load_len=3; stream 3C 01 00 00 34 24 00 50 20 05 00 04 with byte_valid continuously high → done=1 and cpu_hold=0 on the edge of the 12th byte. Then:
   - address 0x00 → 0x3C010000
   - address 0x04 → 0x34240050
   - address 0x0A → 0x20050004
   - words_loaded=3
3. Same load with byte_valid low 1–3 random cycles between bytes → identical memory contents. No byte is accepted while byte_valid=0.
4. load_len=2; after 5 bytes assert reset for 1 cycle → state IDLE, cpu_hold=1. Word 0 is retained; word 1 is unchanged from its prior value. A new start with load_len=1 and bytes AC 82 00 00 → mem[0]=0xAC820000.
5. start with load_len=0 → done=1 one cycle later, memory unchanged. start with load_len=40 → exactly 128 bytes accepted, then done, words_loaded=32, and address 0x7C returns the last word.
6. Pulse start in LOAD after 6 bytes → ignored; the load completes normally. After done, start again → cpu_hold=1 next cycle and a new load overwrites from word 0.
